// File: rtl/video_in_write_if.sv
// Wishbone master write bus between the video-in DMA and RAM.
// Signal names match the legacy flat ports so the top can stay drop-in compatible.
interface video_in_write_if;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_O;
    logic        p_wb_ACK_I;
    logic        p_wb_STB_O;
    logic        p_wb_CYC_O;
    logic        p_wb_LOCK_O;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_WE_O;

    modport master (
        output p_wb_ADR_O, p_wb_DAT_O, p_wb_STB_O, p_wb_CYC_O,
               p_wb_LOCK_O, p_wb_SEL_O, p_wb_WE_O,
        input  p_wb_ACK_I
    );

    modport slave (
        input  p_wb_ADR_O, p_wb_DAT_O, p_wb_STB_O, p_wb_CYC_O,
               p_wb_LOCK_O, p_wb_SEL_O, p_wb_WE_O,
        output p_wb_ACK_I
    );
endinterface

// File: rtl/video_in_write.sv
// Input-side frame DMA: pops pixels from a FWFT FIFO, packs 4 per word (MSB first)
// and writes one frame to RAM at the given base, pulsing interrupt for 4 cycles at the end.
module video_in_write #(
    parameter int unsigned p_WIDTH  = 640,
    parameter int unsigned p_HEIGHT = 480,
    parameter int unsigned NBPACK   = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] wb_reg_data,
    input  logic [31:0] wb_reg_ctr,
    output logic        interrupt,
    video_in_write_if.master wb,
    input  logic        empty,
    input  logic [7:0]  pixel_in,
    output logic        r_e
);
    localparam int unsigned NWORDS = NBPACK / 4;
    localparam int unsigned TOTAL  = p_WIDTH * p_HEIGHT;
    localparam int unsigned PW     = $clog2(TOTAL + 1);
    localparam int unsigned BW     = $clog2(NBPACK + 1);
    localparam int unsigned WW     = $clog2(NWORDS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_BREAK    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]    state_q,   state_d;
    logic          ctr_q;
    logic [31:0]   base_q,    base_d;
    logic [PW-1:0] pix_q,     pix_d;
    logic [BW-1:0] buf_cnt_q, buf_cnt_d;
    logic [WW-1:0] w_q,       w_d;
    logic [1:0]    int_cnt_q, int_cnt_d;
    logic [31:0]   adr_q,     adr_d;
    logic [31:0]   dat_q,     dat_d;
    logic          bus_q,     bus_d;
    logic          irq_q,     irq_d;
    logic [7:0]    pix_buf_q [NBPACK];
    logic [31:0]   word;
    logic          start_edge;
    logic          unused_bits;

    assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};
    assign start_edge  = ~ctr_q & wb_reg_ctr[0];
    assign r_e         = (state_q == S_FILL) & ~empty;

    assign interrupt      = irq_q;
    assign wb.p_wb_ADR_O  = adr_q;
    assign wb.p_wb_DAT_O  = dat_q;
    assign wb.p_wb_STB_O  = bus_q;
    assign wb.p_wb_CYC_O  = bus_q;
    assign wb.p_wb_WE_O   = bus_q;
    assign wb.p_wb_LOCK_O = 1'b0;
    assign wb.p_wb_SEL_O  = 4'hf;

    always_comb begin
        word = '0;
        for (int unsigned k = 0; k < NWORDS; k++) begin
            if (w_q == WW'(k)) begin
                word = {pix_buf_q[4*k], pix_buf_q[4*k+1], pix_buf_q[4*k+2], pix_buf_q[4*k+3]};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        pix_d     = pix_q;
        buf_cnt_d = buf_cnt_q;
        w_d       = w_q;
        int_cnt_d = int_cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        bus_d     = bus_q;
        irq_d     = irq_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    base_d    = {wb_reg_data[31:2], 2'b00};
                    pix_d     = '0;
                    buf_cnt_d = '0;
                    w_d       = '0;
                    state_d   = S_FILL;
                end
            end
            S_FILL: begin
                if (r_e) begin
                    buf_cnt_d = buf_cnt_q + BW'(1);
                    if (buf_cnt_q == BW'(NBPACK - 1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                adr_d   = base_q + 32'(pix_q);
                dat_d   = word;
                bus_d   = 1'b1;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (wb.p_wb_ACK_I) begin
                    bus_d   = 1'b0;
                    pix_d   = pix_q + PW'(4);
                    w_d     = w_q + WW'(1);
                    state_d = S_BREAK;
                end
            end
            S_BREAK: begin
                if (w_q < WW'(NWORDS)) begin
                    state_d = S_WRITE;
                end else begin
                    w_d       = '0;
                    buf_cnt_d = '0;
                    if (pix_q == PW'(TOTAL)) begin
                        irq_d     = 1'b1;
                        int_cnt_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_DONE: begin
                // interrupt was raised on entry; it stays up for int_cnt 0..3
                if (int_cnt_q == 2'd3) begin
                    irq_d     = 1'b0;
                    int_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    int_cnt_d = int_cnt_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ctr_q     <= 1'b1;
            base_q    <= '0;
            pix_q     <= '0;
            buf_cnt_q <= '0;
            w_q       <= '0;
            int_cnt_q <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            bus_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= wb_reg_ctr[0];
            base_q    <= base_d;
            pix_q     <= pix_d;
            buf_cnt_q <= buf_cnt_d;
            w_q       <= w_d;
            int_cnt_q <= int_cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            bus_q     <= bus_d;
            irq_q     <= irq_d;
        end
    end

    // Burst buffer is plain datapath storage; reset only rewinds buf_cnt.
    always_ff @(posedge clk) begin
        if (r_e) begin
            for (int unsigned k = 0; k < NBPACK; k++) begin
                if (buf_cnt_q == BW'(k)) pix_buf_q[k] <= pixel_in;
            end
        end
    end
endmodule

// File: tb/tb_video_in_write.sv
// Self-checking bench for video_in_write (8x2 frame, 8-pixel bursts): FIFO model,
// Wishbone slave with programmable ack delay, and a write scoreboard.
module tb_video_in_write;
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        int          delay;
        bit          erand;
        logic [7:0]  pix0;
        bit          mid;
    } frame_t;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] wb_reg_data = '0;
    logic [31:0] wb_reg_ctr  = 32'd1;
    logic        interrupt;
    logic        empty = 1'b1;
    logic [7:0]  pixel_in = '0;
    logic        r_e;

    video_in_write_if wbif();

    video_in_write #(.p_WIDTH(8), .p_HEIGHT(2), .NBPACK(8)) dut (
        .clk         (clk),
        .RST         (RST),
        .wb_reg_data (wb_reg_data),
        .wb_reg_ctr  (wb_reg_ctr),
        .interrupt   (interrupt),
        .wb          (wbif),
        .empty       (empty),
        .pixel_in    (pixel_in),
        .r_e         (r_e)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    wr_t        sb[$];
    logic [7:0] pixq[$];
    int  ack_delay  = 0;
    bit  empty_rand = 0;
    int  writes = 0;
    int  pops   = 0;
    int  viol   = 0;
    int  irqs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wishbone slave: ack after ack_delay cycles of STB, check hold and scoreboard on ack.
    int          wcnt = 0;
    bit          held = 0;
    logic [31:0] held_adr, held_dat;
    always @(negedge clk) begin
        wr_t e;
        if (RST || !(wbif.p_wb_STB_O && wbif.p_wb_CYC_O)) begin
            wbif.p_wb_ACK_I <= 1'b0;
            wcnt = 0;
            held = 0;
        end else begin
            if (!held) begin
                held_adr = wbif.p_wb_ADR_O;
                held_dat = wbif.p_wb_DAT_O;
                held = 1;
            end else begin
                chk("hold_adr_dat", {wbif.p_wb_ADR_O, wbif.p_wb_DAT_O}, {held_adr, held_dat});
            end
            if (wcnt >= ack_delay) begin
                wbif.p_wb_ACK_I <= 1'b1;
                writes++;
                chk("we_sel_lock", {wbif.p_wb_WE_O, wbif.p_wb_SEL_O, wbif.p_wb_LOCK_O}, 64'b1_1111_0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %0h:%0h expected none",
                             wbif.p_wb_ADR_O, wbif.p_wb_DAT_O);
                end else begin
                    e = sb.pop_front();
                    chk("write_adr_dat", {wbif.p_wb_ADR_O, wbif.p_wb_DAT_O}, {e.adr, e.dat});
                end
            end else begin
                wcnt++;
            end
        end
    end

    // FWFT FIFO model with optional random empty gaps.
    always begin
        bit pop_pend;
        bit gate;
        @(negedge clk);
        pop_pend = r_e;
        if (r_e && empty) viol++;
        @(posedge clk);
        #1;
        if (pop_pend) begin
            if (pixq.size() != 0) void'(pixq.pop_front());
            pops++;
        end
        gate     = empty_rand && ($urandom_range(0, 2) == 0);
        empty    = gate || (pixq.size() == 0);
        pixel_in = (pixq.size() != 0) ? pixq[0] : 8'h00;
    end

    int irq_len = 0;
    always @(negedge clk) begin
        if (interrupt) begin
            irq_len++;
        end else if (irq_len != 0) begin
            chk("irq_len", 64'(irq_len), 64'd4);
            irq_len = 0;
            irqs++;
        end
    end

    task automatic push_pixels(input logic [7:0] p0, input int n);
        for (int i = 0; i < n; i++) pixq.push_back(p0 + 8'(i));
    endtask

    task automatic push_expect(input logic [31:0] base, input logic [7:0] p0);
        wr_t e;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = p0 + 8'(4 * i);
            e.adr = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            e.dat = {b, b + 8'd1, b + 8'd2, b + 8'd3};
            sb.push_back(e);
        end
    endtask

    task automatic start(input logic [31:0] base);
        @(posedge clk); #1;
        wb_reg_data = base;
        wb_reg_ctr  = 32'h0000_0001;
        @(posedge clk); #1;
        wb_reg_ctr  = 32'hFFFF_FFFE;
        wb_reg_data = $urandom;
    endtask

    task automatic run_frame(input frame_t f, input bit push);
        int w0, i0, v0, n;
        ack_delay  = f.delay;
        empty_rand = f.erand;
        w0 = writes;
        i0 = irqs;
        v0 = viol;
        if (push) push_pixels(f.pix0, 16);
        push_expect(f.base, f.pix0);
        start(f.base);
        if (f.mid) begin
            for (n = 0; n < 500 && writes == w0; n++) @(posedge clk);
            #1;
            wb_reg_ctr = 32'd1;
            wb_reg_data = 32'hDEAD_0000;
            @(posedge clk); #1;
            wb_reg_ctr = 32'd0;
        end
        for (n = 0; n < 2000 && irqs == i0; n++) @(posedge clk);
        if (irqs == i0) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no interrupt expected one at base %0h", f.base);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("frame_writes", 64'(writes - w0), 64'd4);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("r_e_while_empty", 64'(viol - v0), 64'd0);
        chk("idle_after_frame", {wbif.p_wb_STB_O, wbif.p_wb_CYC_O, interrupt}, 64'd0);
        empty_rand = 0;
    endtask

    frame_t frames[5];

    initial begin
        int n, w0;
        frames[0] = '{32'h0000_1000, 0, 1'b0, 8'h00, 1'b0};
        frames[1] = '{32'h0000_1000, 0, 1'b1, 8'h00, 1'b0};
        frames[2] = '{32'h0000_5000, 5, 1'b0, 8'h20, 1'b0};
        frames[3] = '{32'h0000_1003, 0, 1'b1, 8'h30, 1'b1};
        frames[4] = '{32'hFFFF_FFF8, 2, 1'b1, 8'hF8, 1'b0};

        repeat (3) begin
            @(posedge clk); #2;
            chk("reset_ctrl", {wbif.p_wb_STB_O, wbif.p_wb_CYC_O, wbif.p_wb_WE_O, interrupt, r_e}, 64'd0);
            chk("reset_bus", {wbif.p_wb_ADR_O, wbif.p_wb_DAT_O}, 64'd0);
        end

        // start bit held high through reset release must not start a frame
        push_pixels(frames[0].pix0, 16);
        @(posedge clk); #1;
        RST = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_start_through_reset", {32'(pops), 32'(writes)}, 64'd0);
        wb_reg_ctr = 32'd0;

        for (int i = 0; i < 5; i++) run_frame(frames[i], i != 0);

        // reset while word 2 waits for ack, then restart at a new base
        ack_delay = 20;
        w0 = writes;
        push_pixels(8'h40, 16);
        push_expect(32'h0000_7000, 8'h40);
        start(32'h0000_7000);
        for (n = 0; n < 1000 && !(writes > w0 && wbif.p_wb_STB_O); n++) begin
            @(posedge clk); #1;
        end
        chk("reached_word2_wait", {32'(writes - w0), 31'd0, wbif.p_wb_STB_O}, {32'd1, 32'd1});
        RST = 1'b1;
        @(posedge clk); #1;
        chk("stb_cyc_after_rst", {wbif.p_wb_STB_O, wbif.p_wb_CYC_O}, 64'd0);
        @(posedge clk); #1;
        RST = 1'b0;
        sb.delete();
        push_pixels(8'h50, 8);
        run_frame('{32'h0000_2000, 0, 1'b0, 8'h48, 1'b0}, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
